multicycle_controller: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath; sits directly upstream of alu_decoder.

---
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback from the opcode, stalling on mem_ready.
module multicycle_controller #(
  parameter int unsigned USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       jump;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   illegal_q, illegal_d;
  logic   rdy;
  logic   pc_write;

  assign rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  // State-only controls, decoded from the state about to be entered so the
  // registered copy always matches the current state.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD, S_MEMWR: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 2'b01;
        c.branch    = 1'b1;
      end
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_src = 2'b10;
        c.jump   = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (rdy) state_d = S_MEMWB;
      S_MEMWR:  if (rdy) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_RST;
    endcase
    ctrl_d = decode(state_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RST;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  // Handshake strobes qualify the registered state with the live ready.
  assign ir_write   = (state_q == S_FETCH) & rdy;
  assign mem_write  = (state_q == S_MEMWR) & rdy;
  assign pc_write   = ir_write | ctrl_q.jump;
  assign pc_en      = pc_write | (ctrl_q.branch & zero);

  assign mem_req    = ctrl_q.mem_req;
  assign iord       = ctrl_q.iord;
  assign reg_dst    = ctrl_q.reg_dst;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src_a  = ctrl_q.alu_src_a;
  assign alu_src_b  = ctrl_q.alu_src_b;
  assign pc_src     = ctrl_q.pc_src;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal_op = illegal_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: a phase-list model per opcode
// predicts every output each cycle; directed runs pin the model with literals.
module tb_multicycle_controller;

  localparam int P_RST = 0, P_FETCH = 1, P_DECODE = 2, P_MEMADR = 3, P_MEMRD = 4,
                 P_MEMWB = 5, P_MEMWR = 6, P_EXEC = 7, P_ALUWB = 8, P_BRANCH = 9,
                 P_ADDIEX = 10, P_ADDIWB = 11, P_JUMP = 12;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] opcode;
  logic       mem_req, mem_write, iord, ir_write, pc_en, reg_dst, mem_to_reg;
  logic       reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, pc_src, alu_op;
  logic [3:0] state_dbg;
  logic [14:0] dut_vec;

  always #5 clk = ~clk;

  multicycle_controller #(.USE_MEM_READY(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_en(pc_en), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src), .alu_op(alu_op),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  assign dut_vec = {mem_req, mem_write, iord, ir_write, pc_en, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, pc_src, alu_op};

  int unsigned n_checks = 0, n_pass = 0;
  int          m_phase;
  int          m_plan[$];
  logic        m_illegal;
  bit          check_en = 1'b0;
  int unsigned mw_count = 0;
  logic        br_pc_en;
  logic [2:0]  jmp_vec;
  int          trace[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Expected outputs for one phase, with the live ready and zero inputs.
  function automatic logic [14:0] model_out(input int ph, input logic r, input logic z);
    logic mreq, mw, io, irw, pce, rd, m2r, rw, asa;
    logic [1:0] asb, pcs, aop;
    {mreq, mw, io, irw, pce, rd, m2r, rw, asa, asb, pcs, aop} = '0;
    case (ph)
      P_FETCH:  begin mreq = 1'b1; irw = r; pce = r; asb = 2'b01; end
      P_DECODE: asb = 2'b11;
      P_MEMADR: begin asa = 1'b1; asb = 2'b10; end
      P_MEMRD:  begin mreq = 1'b1; io = 1'b1; end
      P_MEMWB:  begin m2r = 1'b1; rw = 1'b1; end
      P_MEMWR:  begin mreq = 1'b1; io = 1'b1; mw = r; end
      P_EXEC:   begin asa = 1'b1; aop = 2'b10; end
      P_ALUWB:  begin rd = 1'b1; rw = 1'b1; end
      P_BRANCH: begin asa = 1'b1; aop = 2'b01; pcs = 2'b01; pce = z; end
      P_ADDIEX: begin asa = 1'b1; asb = 2'b10; end
      P_ADDIWB: rw = 1'b1;
      P_JUMP:   begin pcs = 2'b10; pce = 1'b1; end
      default:  ;
    endcase
    return {mreq, mw, io, irw, pce, rd, m2r, rw, asa, asb, pcs, aop};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J};
  endfunction

  // Phases an instruction walks through after its fetch completes.
  task automatic plan_for(input logic [5:0] op);
    m_plan.delete();
    m_plan.push_back(P_DECODE);
    case (op)
      OP_LW:   begin m_plan.push_back(P_MEMADR); m_plan.push_back(P_MEMRD); m_plan.push_back(P_MEMWB); end
      OP_SW:   begin m_plan.push_back(P_MEMADR); m_plan.push_back(P_MEMWR); end
      OP_R:    begin m_plan.push_back(P_EXEC); m_plan.push_back(P_ALUWB); end
      OP_BEQ:  m_plan.push_back(P_BRANCH);
      OP_ADDI: begin m_plan.push_back(P_ADDIEX); m_plan.push_back(P_ADDIWB); end
      OP_J:    m_plan.push_back(P_JUMP);
      default: ;
    endcase
  endtask

  task automatic model_step();
    if (reset) begin
      m_phase = P_RST;
      m_illegal = 1'b0;
      m_plan.delete();
    end else if (m_phase == P_RST) begin
      m_phase = P_FETCH;
    end else if ((m_phase inside {P_FETCH, P_MEMRD, P_MEMWR}) && !mem_ready) begin
      m_phase = m_phase;
    end else begin
      if (m_phase == P_FETCH) plan_for(opcode);
      if (m_phase == P_DECODE && !is_legal(opcode)) m_illegal = 1'b1;
      m_phase = (m_plan.size() > 0) ? m_plan.pop_front() : P_FETCH;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check("outputs", 32'(dut_vec), 32'(model_out(m_phase, mem_ready, zero)));
      check("state_dbg", 32'(state_dbg), 32'(m_phase));
      check("illegal_op", 32'(illegal_op), 32'(m_illegal));
      if (mem_write === 1'b1) mw_count++;
      if (m_phase == P_BRANCH) br_pc_en = pc_en;
      if (m_phase == P_JUMP) jmp_vec = {pc_src, pc_en};
    end
  end

  // Runs one instruction from FETCH back to FETCH; starts just after an edge.
  task automatic run_instr(input logic [5:0] op, input int fetch_stalls, input int mem_stalls,
                           input logic z, output int cycles);
    int fs, ms;
    bit left;
    fs = fetch_stalls;
    ms = mem_stalls;
    left = 1'b0;
    cycles = 0;
    opcode = op;
    zero = z;
    trace.delete();
    do begin
      if (m_phase == P_FETCH) begin
        mem_ready = (fs > 0) ? 1'b0 : 1'b1;
        if (fs > 0) fs--;
      end else if (m_phase inside {P_MEMRD, P_MEMWR}) begin
        mem_ready = (ms > 0) ? 1'b0 : 1'b1;
        if (ms > 0) ms--;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      tick();
      cycles++;
      trace.push_back(int'(state_dbg));
      if (m_phase != P_FETCH) left = 1'b1;
    end while (!(left && m_phase == P_FETCH) && cycles < 64);
    check("instr_done", 32'(left && m_phase == P_FETCH), 32'd1);
  endtask

  initial begin
    int cyc, k, mw0, guard;
    logic [5:0] op;
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    m_phase = P_RST; m_illegal = 1'b0;
    #1;
    check("reset_outputs", 32'(dut_vec), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    check_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("fetch_after_reset", 32'(state_dbg), 32'd1);

    run_instr(OP_R, 0, 0, 1'b0, cyc);
    check("rtype_cycles", 32'(cyc), 32'd4);
    check("rtype_trace_len", 32'(trace.size()), 32'd4);
    if (trace.size() == 4) begin
      check("rtype_s0", 32'(trace[0]), 32'd2);
      check("rtype_s1", 32'(trace[1]), 32'd7);
      check("rtype_s2", 32'(trace[2]), 32'd8);
      check("rtype_s3", 32'(trace[3]), 32'd1);
    end

    run_instr(OP_LW, 0, 3, 1'b0, cyc);
    check("lw_stall_cycles", 32'(cyc), 32'd8);
    run_instr(OP_LW, 0, 0, 1'b0, cyc);
    check("lw_cycles", 32'(cyc), 32'd5);

    br_pc_en = 1'bx;
    run_instr(OP_BEQ, 0, 0, 1'b1, cyc);
    check("beq_taken_pc_en", 32'(br_pc_en), 32'd1);
    check("beq_cycles", 32'(cyc), 32'd3);
    br_pc_en = 1'bx;
    run_instr(OP_BEQ, 0, 0, 1'b0, cyc);
    check("beq_not_taken_pc_en", 32'(br_pc_en), 32'd0);

    mw0 = int'(mw_count);
    run_instr(OP_SW, 2, 2, 1'b0, cyc);
    check("sw_mem_write_pulses", 32'(int'(mw_count) - mw0), 32'd1);
    check("sw_cycles", 32'(cyc), 32'd8);
    jmp_vec = 'x;
    run_instr(OP_J, 3, 0, 1'b0, cyc);
    check("j_pc_src_pc_en", 32'(jmp_vec), 32'b101);
    check("j_cycles", 32'(cyc), 32'd6);
    run_instr(OP_ADDI, 1, 0, 1'b1, cyc);
    check("addi_cycles", 32'(cyc), 32'd5);

    run_instr(OP_BAD, 0, 0, 1'b0, cyc);
    check("illegal_cycles", 32'(cyc), 32'd2);
    check("illegal_set", 32'(illegal_op), 32'd1);
    run_instr(OP_R, 0, 0, 1'b0, cyc);
    run_instr(OP_SW, 1, 1, 1'b0, cyc);
    check("illegal_sticky", 32'(illegal_op), 32'd1);

    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 13));
      case (k / 2)
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_R;
        3: op = OP_BEQ;
        4: op = OP_ADDI;
        5: op = OP_J;
        default: op = 6'($urandom);
      endcase
      run_instr(op, int'($urandom_range(0, 3)) - 1 > 0 ? int'($urandom_range(1, 3)) : 0,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), cyc);
    end

    // Asynchronous reset in the middle of a stalled load.
    opcode = OP_LW;
    guard = 0;
    mem_ready = 1'b1;
    while (m_phase != P_MEMRD && guard < 20) begin
      tick();
      guard++;
    end
    check("reached_memrd", 32'(m_phase), 32'(P_MEMRD));
    mem_ready = 1'b0;
    #1;
    check("memrd_mem_req", 32'(mem_req), 32'd1);
    #1;
    reset = 1'b1;
    m_phase = P_RST; m_illegal = 1'b0; m_plan.delete();
    #1;
    check("async_reset_outputs", 32'(dut_vec), 32'd0);
    check("async_reset_state", 32'(state_dbg), 32'd0);
    check("async_reset_illegal", 32'(illegal_op), 32'd0);
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    tick();
    check("fetch_after_async_reset", 32'(state_dbg), 32'd1);
    run_instr(OP_R, 0, 0, 1'b0, cyc);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
